// File: rtl/ddr3_bist_sequencer.sv
// DDR3 EMIF built-in self-test: waits for calibration, then writes and reads back a
// seeded pattern in two passes (true, then inverted) and reports status for the Nios PIO.
module ddr3_bist_sequencer #(
    parameter int          ADDR_W     = 26,
    parameter int          DATA_W     = 64,
    parameter int          TEST_WORDS = 1024,
    parameter logic [31:0] SEED       = 32'hA5C3_0F1E,
    parameter int          MAX_OUTST  = 8,
    parameter int          CAL_TMO    = 2**20
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic                local_init_done,
    input  logic                local_cal_success,
    input  logic                local_cal_fail,
    input  logic                avl_ready,
    output logic [ADDR_W-1:0]   avl_addr,
    output logic                avl_write_req,
    output logic                avl_read_req,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic [DATA_W/8-1:0] avl_be,
    output logic [2:0]          avl_size,
    input  logic [DATA_W-1:0]   avl_rdata,
    input  logic                avl_rdata_valid,
    output logic [3:0]          status,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTST) + 1;
    localparam int TMO_W = $clog2(CAL_TMO) + 1;

    localparam logic [CNT_W-1:0] C_WORDS    = CNT_W'(TEST_WORDS);
    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(TEST_WORDS - 1);
    localparam logic [OUT_W-1:0] C_MAXO     = OUT_W'(MAX_OUTST);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(CAL_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_rx;
    logic [OUT_W-1:0]   r_outst;
    logic [TMO_W-1:0]   r_cal_cnt;
    logic               r_pass_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write_req;
    logic               r_read_req;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_fail;
    logic               r_pass_ok;
    logic               r_busy;
    logic               r_cal_ok;
    logic [15:0]        r_err;
    logic [ADDR_W-1:0]  r_first;

    logic               w_wr_accept;
    logic               w_rd_accept;
    logic               w_rx_take;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_idx_inc;
    logic [CNT_W-1:0]   w_issued_nxt;
    logic [OUT_W-1:0]   w_outst_nxt;

    // Pattern word i is (i ^ SEED) replicated across the bus; pass 1 uses its inverse.
    function automatic logic [DATA_W-1:0] f_pattern(input logic [CNT_W-1:0] idx, input logic inv);
        logic [31:0]       word;
        logic [DATA_W-1:0] pat;
        word = 32'(idx) ^ SEED;
        pat  = '0;
        for (int k = 0; k < DATA_W / 32; k++) begin
            pat[k*32 +: 32] = word;
        end
        return inv ? ~pat : pat;
    endfunction

    assign w_wr_accept  = r_write_req & avl_ready;
    assign w_rd_accept  = r_read_req & avl_ready;
    assign w_rx_take    = avl_rdata_valid && (r_state == S_READ || r_state == S_DRAIN) && (r_rx != C_WORDS);
    assign w_mismatch   = w_rx_take && (avl_rdata != f_pattern(r_rx, r_pass_idx));
    assign w_idx_inc    = r_idx + CNT_W'(1);
    assign w_issued_nxt = w_rd_accept ? w_idx_inc : r_idx;

    // A simultaneous accept and response cancel out in the outstanding count.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_rd_accept && !w_rx_take) begin
            w_outst_nxt = r_outst + OUT_W'(1);
        end else if (!w_rd_accept && w_rx_take) begin
            w_outst_nxt = r_outst - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rx        <= '0;
            r_outst     <= '0;
            r_cal_cnt   <= '0;
            r_pass_idx  <= 1'b0;
            r_addr      <= '0;
            r_write_req <= 1'b0;
            r_read_req  <= 1'b0;
            r_wdata     <= '0;
            r_fail      <= 1'b0;
            r_pass_ok   <= 1'b0;
            r_busy      <= 1'b0;
            r_cal_ok    <= 1'b0;
            r_err       <= '0;
            r_first     <= '0;
        end else begin
            if (w_rx_take) begin
                r_rx <= r_rx + CNT_W'(1);
            end
            if (w_mismatch) begin
                if (r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
                if (r_err == 16'd0) begin
                    r_first <= r_rx[ADDR_W-1:0];
                end
            end
            r_outst <= w_outst_nxt;

            case (r_state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        r_state    <= S_WAIT_CAL;
                        r_busy     <= 1'b1;
                        r_cal_ok   <= 1'b0;
                        r_pass_ok  <= 1'b0;
                        r_fail     <= 1'b0;
                        r_err      <= '0;
                        r_first    <= '0;
                        r_pass_idx <= 1'b0;
                        r_idx      <= '0;
                        r_rx       <= '0;
                        r_outst    <= '0;
                        r_cal_cnt  <= '0;
                    end
                end
                S_WAIT_CAL: begin
                    if (local_cal_fail) begin
                        r_state <= S_FAIL;
                        r_busy  <= 1'b0;
                        r_fail  <= 1'b1;
                    end else if (local_init_done && local_cal_success) begin
                        r_state     <= S_WRITE;
                        r_cal_ok    <= 1'b1;
                        r_idx       <= '0;
                        r_write_req <= 1'b1;
                        r_addr      <= '0;
                        r_wdata     <= f_pattern('0, 1'b0);
                    end else if (r_cal_cnt == C_TMO_LAST) begin
                        r_state <= S_FAIL;
                        r_busy  <= 1'b0;
                        r_fail  <= 1'b1;
                    end else begin
                        r_cal_cnt <= r_cal_cnt + TMO_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_wr_accept) begin
                        if (r_idx == C_LAST) begin
                            r_state     <= S_READ;
                            r_idx       <= '0;
                            r_write_req <= 1'b0;
                            r_wdata     <= '0;
                            r_read_req  <= 1'b1;
                            r_addr      <= '0;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_addr  <= w_idx_inc[ADDR_W-1:0];
                            r_wdata <= f_pattern(w_idx_inc, r_pass_idx);
                        end
                    end
                end
                S_READ: begin
                    // Only request when the post-edge outstanding count still has room, so
                    // a pending request can never overshoot the limit while it waits.
                    r_idx <= w_issued_nxt;
                    if (w_issued_nxt == C_WORDS) begin
                        r_state    <= S_DRAIN;
                        r_read_req <= 1'b0;
                    end else if (w_outst_nxt < C_MAXO) begin
                        r_read_req <= 1'b1;
                        r_addr     <= w_issued_nxt[ADDR_W-1:0];
                    end else begin
                        r_read_req <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_rx == C_WORDS) begin
                        if (!r_pass_idx) begin
                            r_state     <= S_WRITE;
                            r_pass_idx  <= 1'b1;
                            r_idx       <= '0;
                            r_rx        <= '0;
                            r_outst     <= '0;
                            r_write_req <= 1'b1;
                            r_addr      <= '0;
                            r_wdata     <= f_pattern('0, 1'b1);
                        end else begin
                            r_busy <= 1'b0;
                            if (r_err == 16'd0) begin
                                r_state   <= S_PASS;
                                r_pass_ok <= 1'b1;
                            end else begin
                                r_state <= S_FAIL;
                                r_fail  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign avl_addr       = r_addr;
    assign avl_write_req  = r_write_req;
    assign avl_read_req   = r_read_req;
    assign avl_wdata      = r_wdata;
    assign avl_be         = '1;
    assign avl_size       = 3'd1;
    assign status         = {r_fail, r_pass_ok, r_busy, r_cal_ok};
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: tb/tb_ddr3_bist_sequencer.sv
// Scoreboarded bench for ddr3_bist_sequencer: a randomized Avalon memory model answers the
// DUT, the expected command stream and final status come from the pattern rules.
module tb_ddr3_bist_sequencer;

    localparam int          ADDR_W = 12;
    localparam int          DATA_W = 64;
    localparam int          N      = 16;
    localparam logic [31:0] SEED   = 32'hA5C3_0F1E;
    localparam int          MAXO   = 4;

    typedef struct {
        bit                isWrite;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct {
        logic [3:0]        status;
        logic [15:0]       errs;
        logic [ADDR_W-1:0] first;
        int                nWr;
        int                nRd;
    } res_t;

    typedef struct {
        longint            due;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstN;
    logic                start;
    logic                initDone;
    logic                calSuccess;
    logic                calFail;
    logic                avlReady;
    logic [DATA_W-1:0]   rdata;
    logic                rdataValid;
    logic [ADDR_W-1:0]   avlAddr;
    logic                avlWriteReq;
    logic                avlReadReq;
    logic [DATA_W-1:0]   avlWdata;
    logic [DATA_W/8-1:0] avlBe;
    logic [2:0]          avlSize;
    logic [3:0]          status;
    logic [15:0]         errCount;
    logic [ADDR_W-1:0]   firstErrAddr;

    logic                start2;
    logic [DATA_W-1:0]   zeroData;
    logic [ADDR_W-1:0]   addr2;
    logic                wr2;
    logic                rd2;
    logic [DATA_W-1:0]   wdata2;
    logic [DATA_W/8-1:0] be2;
    logic [2:0]          size2;
    logic [3:0]          status2;
    logic [15:0]         err2;
    logic [ADDR_W-1:0]   first2;

    ddr3_bist_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEST_WORDS(N), .SEED(SEED),
        .MAX_OUTST(MAXO), .CAL_TMO(1000)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rstN), .start(start),
        .local_init_done(initDone), .local_cal_success(calSuccess), .local_cal_fail(calFail),
        .avl_ready(avlReady), .avl_addr(avlAddr), .avl_write_req(avlWriteReq),
        .avl_read_req(avlReadReq), .avl_wdata(avlWdata), .avl_be(avlBe), .avl_size(avlSize),
        .avl_rdata(rdata), .avl_rdata_valid(rdataValid), .status(status),
        .err_count(errCount), .first_err_addr(firstErrAddr)
    );

    // Second instance exists only to exercise the calibration timeout with a short limit.
    ddr3_bist_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEST_WORDS(N), .SEED(SEED),
        .MAX_OUTST(MAXO), .CAL_TMO(64)
    ) dutTmo (
        .clk_clk(clk), .reset_reset_n(rstN), .start(start2),
        .local_init_done(1'b0), .local_cal_success(1'b0), .local_cal_fail(1'b0),
        .avl_ready(1'b1), .avl_addr(addr2), .avl_write_req(wr2),
        .avl_read_req(rd2), .avl_wdata(wdata2), .avl_be(be2), .avl_size(size2),
        .avl_rdata(zeroData), .avl_rdata_valid(1'b0), .status(status2),
        .err_count(err2), .first_err_addr(first2)
    );

    int     assertCount = 0;
    int     failCount   = 0;
    cmd_t   expCmd[$];
    res_t   expRes[$];
    rsp_t   pend[$];
    bit     faultMap[2][N];
    logic [DATA_W-1:0] mem[N];
    bit     readyRandom = 1'b0;
    int     latMax      = 1;
    int     rspReads    = 0;
    longint cyc         = 0;
    longint lastDue     = 0;

    bit                heldValid = 1'b0;
    bit                heldWr;
    bit                heldRd;
    logic [ADDR_W-1:0] heldAddr;
    logic [DATA_W-1:0] heldData;
    int                outst    = 0;
    bit                busyPrev = 1'b0;
    int                runWr    = 0;
    int                runRd    = 0;

    function automatic logic [DATA_W-1:0] refPattern(input int i, input bit inv);
        logic [31:0]       w;
        logic [DATA_W-1:0] p;
        w = 32'(i) ^ SEED;
        p = {(DATA_W/32){w}};
        return inv ? ~p : p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Memory model: stores writes, answers reads in order after a random latency.
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        rsp_t              r;
        if (!rstN) begin
            pend.delete();
            rdataValid = 1'b0;
            avlReady   = 1'b0;
            lastDue    = 0;
        end else begin
            rdataValid = 1'b0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                rdata      = pend[0].data;
                rdataValid = 1'b1;
                pend.delete(0);
            end
            avlReady = readyRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (avlReady && avlWriteReq && int'(avlAddr) < N) begin
                mem[avlAddr] = avlWdata;
            end
            if (avlReady && avlReadReq) begin
                d = (int'(avlAddr) < N) ? mem[avlAddr] : '0;
                if (int'(avlAddr) < N && faultMap[(rspReads >= N) ? 1 : 0][avlAddr]) begin
                    d[0] = ~d[0];
                end
                rspReads++;
                r.due  = cyc + longint'($urandom_range(1, latMax));
                if (r.due < lastDue) r.due = lastDue;
                lastDue = r.due;
                r.data  = d;
                pend.push_back(r);
            end
            cyc++;
        end
    end

    // Monitor: samples mid-cycle after the memory model has driven its inputs.
    always @(negedge clk) begin
        cmd_t c;
        res_t r;
        #1;
        if (!rstN) begin
            heldValid = 1'b0;
            outst     = 0;
            busyPrev  = 1'b0;
        end else begin
            if (avlWriteReq || avlReadReq) begin
                checkOutput("wr_rd_exclusive", 64'(avlWriteReq & avlReadReq), 64'(0));
            end
            if (heldValid) begin
                checkOutput("hold_req", 64'({avlWriteReq, avlReadReq}), 64'({heldWr, heldRd}));
                checkOutput("hold_addr", 64'(avlAddr), 64'(heldAddr));
                if (heldWr) checkOutput("hold_wdata", avlWdata, heldData);
            end
            if ((avlWriteReq || avlReadReq) && avlReady) begin
                if (expCmd.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_cmd: actual wr=%0b rd=%0b addr=%0h expected none",
                             avlWriteReq, avlReadReq, avlAddr);
                end else begin
                    c = expCmd.pop_front();
                    checkOutput("cmd_kind", 64'(avlWriteReq), 64'(c.isWrite));
                    checkOutput("cmd_addr", 64'(avlAddr), 64'(c.addr));
                    if (c.isWrite) checkOutput("cmd_wdata", avlWdata, c.data);
                end
                if (avlWriteReq) runWr++;
                if (avlReadReq) begin
                    runRd++;
                    outst++;
                    checkOutput("outstanding_limit", 64'(outst > MAXO), 64'(0));
                end
            end
            if (rdataValid) outst--;
            heldValid = (avlWriteReq || avlReadReq) && !avlReady;
            heldWr    = avlWriteReq;
            heldRd    = avlReadReq;
            heldAddr  = avlAddr;
            heldData  = avlWdata;
            if (status[1] && !busyPrev) begin
                runWr = 0;
                runRd = 0;
            end
            if (!status[1] && busyPrev) begin
                if (expRes.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_done: actual status=%0b expected no run", status);
                end else begin
                    r = expRes.pop_front();
                    checkOutput("final_status", 64'(status), 64'(r.status));
                    checkOutput("err_count", 64'(errCount), 64'(r.errs));
                    checkOutput("first_err_addr", 64'(firstErrAddr), 64'(r.first));
                    checkOutput("write_count", 64'(runWr), 64'(r.nWr));
                    checkOutput("read_count", 64'(runRd), 64'(r.nRd));
                end
            end
            busyPrev = status[1];
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_status"}, 64'(status), 64'(0));
        checkOutput({tag, "_err"}, 64'(errCount), 64'(0));
        checkOutput({tag, "_first"}, 64'(firstErrAddr), 64'(0));
        checkOutput({tag, "_wr"}, 64'(avlWriteReq), 64'(0));
        checkOutput({tag, "_rd"}, 64'(avlReadReq), 64'(0));
        checkOutput({tag, "_addr"}, 64'(avlAddr), 64'(0));
        checkOutput({tag, "_wdata"}, avlWdata, 64'(0));
        checkOutput({tag, "_be"}, 64'(avlBe), 64'(8'hFF));
        checkOutput({tag, "_size"}, 64'(avlSize), 64'(1));
    endtask

    task automatic recoverDut();
        @(negedge clk);
        #3 rstN = 1'b0;
        expCmd.delete();
        expRes.delete();
        repeat (2) @(negedge clk);
        #3 rstN = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (expRes.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expRes.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL run_timeout: actual still busy after %0d cycles, required completion", budget);
            recoverDut();
        end
    endtask

    task automatic applyStimulus(input int calDelay, input bit failCal, input bit randReady,
                                 input int maxLat, input int fixedFault, input int nRand, input bit doWait);
        cmd_t c;
        res_t r;
        int   errs  = 0;
        int   first = 0;
        readyRandom = randReady;
        latMax      = maxLat;
        rspReads    = 0;
        for (int p = 0; p < 2; p++) for (int w = 0; w < N; w++) faultMap[p][w] = 1'b0;
        if (fixedFault >= 0) faultMap[1][fixedFault] = 1'b1;
        for (int k = 0; k < nRand; k++) faultMap[$urandom_range(0, 1)][$urandom_range(0, N - 1)] = 1'b1;
        r.nWr = 0;
        r.nRd = 0;
        if (!failCal) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < N; i++) begin
                    c.isWrite = 1'b1;
                    c.addr    = ADDR_W'(i);
                    c.data    = refPattern(i, p == 1);
                    expCmd.push_back(c);
                end
                for (int i = 0; i < N; i++) begin
                    c.isWrite = 1'b0;
                    c.addr    = ADDR_W'(i);
                    c.data    = '0;
                    expCmd.push_back(c);
                    if (faultMap[p][i]) begin
                        if (errs == 0) first = i;
                        errs++;
                    end
                end
            end
            r.nWr    = 2 * N;
            r.nRd    = 2 * N;
            r.status = (errs == 0) ? 4'b0101 : 4'b1001;
        end else begin
            r.status = 4'b1000;
        end
        r.errs  = 16'(errs);
        r.first = ADDR_W'(first);
        expRes.push_back(r);
        @(negedge clk);
        initDone   = 1'b0;
        calSuccess = 1'b0;
        calFail    = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (calDelay) @(negedge clk);
        if (failCal) calFail = 1'b1;
        else begin
            initDone   = 1'b1;
            calSuccess = 1'b1;
        end
        if (doWait) waitIdle(4000);
    endtask

    task automatic runResetMidRead();
        int n = 0;
        applyStimulus(10, 1'b0, 1'b1, 20, -1, 0, 1'b0);
        while (runRd < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_read_phase", 64'(runRd >= 3), 64'(1));
        @(negedge clk);
        #3 rstN = 1'b0;
        #1 checkResetOutputs("midrun_rst");
        expCmd.delete();
        expRes.delete();
        start      = 1'b0;
        initDone   = 1'b0;
        calSuccess = 1'b0;
        repeat (2) @(negedge clk);
        #3 rstN = 1'b1;
        applyStimulus(10, 1'b0, 1'b1, 20, -1, 0, 1'b1);
    endtask

    task automatic runTimeoutTest();
        int cycles = 0;
        bit done   = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        while (cycles < 200 && !done) begin
            @(negedge clk);
            start2 = (cycles == 30);
            if (status2[3]) done = 1'b1;
            else begin
                if (cycles == 10) checkOutput("tmo_busy", 64'(status2), 64'(4'b0010));
                cycles++;
            end
        end
        start2 = 1'b0;
        checkOutput("tmo_reached", 64'(done), 64'(1));
        checkOutput("tmo_cycles", 64'(cycles), 64'(64));
        checkOutput("tmo_status", 64'(status2), 64'(4'b1000));
        checkOutput("tmo_no_cmd", 64'({wr2, rd2}), 64'(0));
    endtask

    initial begin
        rstN       = 1'b0;
        start      = 1'b0;
        start2     = 1'b0;
        initDone   = 1'b0;
        calSuccess = 1'b0;
        calFail    = 1'b0;
        rdata      = '0;
        zeroData   = '0;
        repeat (3) @(negedge clk);
        #1 checkResetOutputs("por");
        #2 rstN = 1'b1;

        // A stray response while idle must not be counted by the compare logic.
        @(negedge clk);
        #2 rdata = {$urandom, $urandom};
        rdataValid = 1'b1;

        $display("[TB] ideal memory, calibration after 100 cycles");
        applyStimulus(100, 1'b0, 1'b0, 1, -1, 0, 1'b1);
        $display("[TB] bit 0 flipped at word 5 in pass 1");
        applyStimulus(20, 1'b0, 1'b0, 3, 5, 0, 1'b1);
        $display("[TB] calibration failure");
        applyStimulus(30, 1'b1, 1'b0, 1, -1, 0, 1'b1);
        $display("[TB] random ready and latency");
        applyStimulus(5, 1'b0, 1'b1, 20, -1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($urandom_range(1, 20), 1'b0, 1'b1, $urandom_range(1, 20), -1,
                          $urandom_range(0, 3), 1'b1);
        end
        $display("[TB] reset during read phase");
        runResetMidRead();
        $display("[TB] calibration timeout");
        runTimeoutTest();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
